// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: load/store front end for the dm_4k data memory.
// Takes one request per valid/ready handshake and rejects illegal sizes,
// misaligned and out-of-range accesses before touching memory. Halfword
// stores become two byte writes. Sub-word loads are extracted from the
// returned word and extended. Every accepted request ends in a one-cycle
// response strobe.
module dm_access_ctrl #(
   parameter int unsigned DM_BYTES = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_din,
   output logic        dm_we,
   output logic        dm_DMop,
   input  logic [31:0] dm_dout
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_STW  = 3'd2;
   localparam logic [2:0] ST_STB  = 3'd3;
   localparam logic [2:0] ST_STH0 = 3'd4;
   localparam logic [2:0] ST_STH1 = 3'd5;
   localparam logic [2:0] ST_RSP  = 3'd6;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [2:0]  state_q, state_d;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        accept;
   logic        req_err;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_data;

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RSP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign accept    = req_valid & req_ready;

   // Reject illegal size, misaligned half/word and addresses past the end of DM.
   assign req_err = (req_size == 2'b11)
                 || ((req_size == SZ_HALF) && req_addr[0])
                 || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                 || (req_addr >= 32'(DM_BYTES));

   // Little-endian lane selection within the word DM returns for addr[11:2].
   assign byte_lane = dm_dout[{addr_q[1:0], 3'b000} +: 8];
   assign half_lane = dm_dout[{addr_q[1], 4'b0000} +: 16];

   // Extract and extend the addressed lane for the latched load size.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      load_data = '0;
      case (size_q)
         SZ_BYTE: load_data = uns_q ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
         SZ_HALF: load_data = uns_q ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
         default: load_data = dm_dout;
      endcase
   end

   // Next state plus the response registers, which only change on entry to RSP.
   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (req_err) begin
                  state_d = ST_RSP;
                  rdata_d = '0;
                  err_d   = 1'b1;
               end else if (!req_we) begin
                  state_d = ST_LOAD;
               end else begin
                  case (req_size)
                     SZ_WORD: state_d = ST_STW;
                     SZ_BYTE: state_d = ST_STB;
                     default: state_d = ST_STH0;
                  endcase
               end
            end
         end
         ST_LOAD: begin
            state_d = ST_RSP;
            rdata_d = load_data;
            err_d   = 1'b0;
         end
         ST_STW, ST_STB, ST_STH1: begin
            state_d = ST_RSP;
            rdata_d = '0;
            err_d   = 1'b0;
         end
         ST_STH0: state_d = ST_STH1;
         ST_RSP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: sequential state uses <= so every register samples pre-edge values.
         state_q <= state_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Request fields are captured only on the accept edge; direction lives in the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         size_q  <= '0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         size_q  <= req_size;
         uns_q   <= req_unsigned;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   // DM drive decoded from state; reset forces IDLE so dm_we drops at once.
   always_comb begin
      dm_we   = 1'b0;
      dm_DMop = 1'b0;
      dm_addr = addr_q;
      dm_din  = '0;
      case (state_q)
         ST_STW: begin
            dm_we  = 1'b1;
            dm_din = wdata_q;
         end
         ST_STB, ST_STH0: begin
            dm_we   = 1'b1;
            dm_DMop = 1'b1;
            dm_din  = {24'b0, wdata_q[7:0]};
         end
         ST_STH1: begin
            dm_we   = 1'b1;
            dm_DMop = 1'b1;
            dm_addr = addr_q + 32'd1;
            dm_din  = {24'b0, wdata_q[15:8]};
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a behavioural dm_4k model.
// Expected responses come from a byte-array reference memory and are queued
// when each request is driven, then popped when rsp_valid appears.
module tb_dm_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] dm_addr;
   logic [31:0] dm_din;
   logic        dm_we;
   logic        dm_DMop;
   logic [31:0] dm_dout;

   dm_access_ctrl #(.DM_BYTES(4096)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
      .dm_DMop(dm_DMop), .dm_dout(dm_dout)
   );

   always #5 clk = ~clk;

   // dm_4k model: byte or word write on the rising edge, combinational word read.
   typedef struct {
      logic [31:0] addr;
      logic [31:0] din;
      logic        op;
   } wr_t;

   logic [31:0] dm_mem [1024] = '{default: 32'h0};
   wr_t         wr_log [$];

   assign dm_dout = dm_mem[dm_addr[11:2]];

   always @(posedge clk) begin
      if (dm_we) begin
         if (dm_DMop) dm_mem[dm_addr[11:2]][{dm_addr[1:0], 3'b000} +: 8] <= dm_din[7:0];
         else         dm_mem[dm_addr[11:2]] <= dm_din;
         wr_log.push_back('{dm_addr, dm_din, dm_DMop});
      end
   end

   // Scoreboard and reference memory.
   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t       sb_q [$];
   logic [7:0] ref_mem [4096] = '{default: 8'h0};
   int         n_checks = 0;
   int         n_fail = 0;
   int         log_base;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request at a negedge, predict its result, wait for the response.
   task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
      exp_t e;
      int   cyc;
      logic [31:0] v;
      e.tag = tag;
      e.err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
              || (a >= 32'd4096);
      e.rdata = '0;
      e.lat = e.err ? 1 : ((we && sz == 2'b01) ? 3 : 2);
      if (!e.err && we) begin
         ref_mem[a[11:0]] = wd[7:0];
         if (sz != 2'b00) ref_mem[a[11:0] + 12'd1] = wd[15:8];
         if (sz == 2'b10) begin
            ref_mem[a[11:0] + 12'd2] = wd[23:16];
            ref_mem[a[11:0] + 12'd3] = wd[31:24];
         end
      end else if (!e.err) begin
         v = {ref_mem[{a[11:2], 2'b11}], ref_mem[{a[11:2], 2'b10}],
              ref_mem[{a[11:2], 2'b01}], ref_mem[{a[11:2], 2'b00}]};
         case (sz)
            2'b00: begin
               v = {24'b0, ref_mem[a[11:0]]};
               e.rdata = (uns || !v[7]) ? v : (v | 32'hFFFFFF00);
            end
            2'b01: begin
               v = {16'b0, ref_mem[a[11:0] + 12'd1], ref_mem[a[11:0]]};
               e.rdata = (uns || !v[15]) ? v : (v | 32'hFFFF0000);
            end
            default: e.rdata = v;
         endcase
      end
      sb_q.push_back(e);

      check({tag, " ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF; req_size = 2'b11;
      cyc = 1;
      while (!rsp_valid && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      e = sb_q.pop_front();
      if (!rsp_valid) begin
         check({e.tag, " timeout"}, 32'(rsp_valid), 32'd1);
      end else begin
         check({e.tag, " latency"}, 32'(cyc), 32'(e.lat));
         check({e.tag, " rdata"}, rsp_rdata, e.rdata);
         check({e.tag, " err"}, 32'(rsp_err), 32'(e.err));
         check({e.tag, " busy in rsp"}, 32'(req_ready), 32'd0);
         @(negedge clk);
         check({e.tag, " one-cycle rsp"}, 32'(rsp_valid), 32'd0);
         check({e.tag, " rdata held"}, rsp_rdata, e.rdata);
      end
   endtask

   initial begin
      logic saw_rsp;
      // Reset state.
      #3;
      check("rst ready", 32'(req_ready), 32'd1);
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst rdata", rsp_rdata, 32'd0);
      check("rst err", 32'(rsp_err), 32'd0);
      check("rst dm_we", 32'(dm_we), 32'd0);
      check("rst dm_DMop", 32'(dm_DMop), 32'd0);
      check("rst dm_addr", dm_addr, 32'd0);
      check("rst dm_din", dm_din, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Word store/load and sub-word loads.
      do_req("sw 10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
      do_req("lw 10", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
      check("lw 10 const", rsp_rdata, 32'hDEADBEEF);
      do_req("lb 13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
      check("lb 13 const", rsp_rdata, 32'hFFFFFFDE);
      do_req("lbu 13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
      check("lbu 13 const", rsp_rdata, 32'h000000DE);
      do_req("lh 12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
      check("lh 12 const", rsp_rdata, 32'hFFFFDEAD);
      do_req("lhu 10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
      do_req("lb 10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);

      // Halfword store split into two byte writes.
      do_req("sw 20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
      log_base = wr_log.size();
      do_req("sh 22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234A5C3);
      check("sh writes", 32'(wr_log.size() - log_base), 32'd2);
      if (wr_log.size() - log_base == 2) begin
         check("sh w0 addr", wr_log[log_base].addr, 32'h22);
         check("sh w0 din", wr_log[log_base].din, 32'h000000C3);
         check("sh w0 op", 32'(wr_log[log_base].op), 32'd1);
         check("sh w1 addr", wr_log[log_base+1].addr, 32'h23);
         check("sh w1 din", wr_log[log_base+1].din, 32'h000000A5);
         check("sh w1 op", 32'(wr_log[log_base+1].op), 32'd1);
      end
      do_req("lw 20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      check("lw 20 const", rsp_rdata, 32'hA5C3BEEF);

      // Errors: no DM write may happen.
      log_base = wr_log.size();
      do_req("lw 21", 1'b0, 2'b10, 1'b0, 32'h21, 32'h0);
      do_req("lh 23", 1'b0, 2'b01, 1'b0, 32'h23, 32'h0);
      do_req("size11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
      do_req("sw 22", 1'b1, 2'b10, 1'b0, 32'h22, 32'h11111111);
      do_req("sh 25", 1'b1, 2'b01, 1'b0, 32'h25, 32'h2222);
      do_req("sb 1000", 1'b1, 2'b00, 1'b0, 32'h1000, 32'h77);
      do_req("sw big", 1'b1, 2'b10, 1'b0, 32'h8000_0000, 32'h33333333);
      check("err no writes", 32'(wr_log.size() - log_base), 32'd0);
      do_req("lw 0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
      do_req("lw 20 again", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

      // Top of memory.
      do_req("sb FFF", 1'b1, 2'b00, 1'b0, 32'hFFF, 32'hFFFFFF5A);
      do_req("lbu FFF", 1'b0, 2'b00, 1'b1, 32'hFFF, 32'h0);
      check("lbu FFF const", rsp_rdata, 32'h0000005A);
      do_req("sb FFE", 1'b1, 2'b00, 1'b0, 32'hFFE, 32'h0000009C);
      do_req("lb FFE", 1'b0, 2'b00, 1'b0, 32'hFFE, 32'h0);
      do_req("lw FFC", 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);

      // Reset during STH1: only the low byte lands, no response.
      check("pre-rst ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
      req_addr = 32'h40; req_wdata = 32'h00001234;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("sth1 dm_we", 32'(dm_we), 32'd1);
      check("sth1 dm_addr", dm_addr, 32'h41);
      ref_mem[12'h40] = 8'h34;
      rst = 1'b1;
      #1;
      check("rst dm_we drop", 32'(dm_we), 32'd0);
      saw_rsp = 1'b0;
      repeat (3) begin
         @(negedge clk);
         saw_rsp = saw_rsp | rsp_valid;
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         saw_rsp = saw_rsp | rsp_valid;
      end
      check("no rsp after abort", 32'(saw_rsp), 32'd0);
      check("ready after rst", 32'(req_ready), 32'd1);
      do_req("lw 40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
      check("lw 40 const", rsp_rdata, 32'h00000034);

      check("scoreboard empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
